mandel_engine: RTL and testbench



---
 rtl/mandel_engine.sv | 172 +++++++++++++++++
 tb/tb_mandel_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_engine.sv
// rtl/mandel_engine.sv - Mandelbrot iteration engine scanning a programmable pixel rectangle
// Iterates z <- z^2 + c per pixel in signed fixed point; results leave on a valid/ready stream.
module mandel_engine #(
  parameter int W       = 16,
  parameter int FRAC    = 12,
  parameter int ITER_W  = 16,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [COORD_W-1:0] cfg_pix_w,
  input  logic [COORD_W-1:0] cfg_pix_h,
  input  logic [W-1:0]       cfg_cxs,
  input  logic [W-1:0]       cfg_cys,
  input  logic [W-1:0]       cfg_dcx,
  input  logic [W-1:0]       cfg_dcy,
  input  logic [ITER_W-1:0]  cfg_max_iter,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [ITER_W-1:0]  out_iter,
  output logic               out_inside
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL,
    S_CHK,
    S_WRITE,
    S_DONE
  } state_t;

  // |z|^2 >= 4 expressed in the 2*FRAC fraction bits of the product domain
  localparam logic [2*W:0] ESC_LIMIT = (2*W+1)'(1) << (2*FRAC + 2);

  state_t state;

  logic [COORD_W-1:0]    pix_w, pix_h, px, py;
  logic signed [W-1:0]   cxs, cys, dcx, dcy, cx, cy, x, y;
  logic [ITER_W-1:0]     max_iter, i;
  logic signed [2*W-1:0] xx, yy, xy;

  logic [2*W:0]          mag;
  logic                  escape;
  logic signed [W-1:0]   x_next, y_next;

  always_comb begin
    mag    = (2*W+1)'(xx) + (2*W+1)'(yy);
    escape = (mag >= ESC_LIMIT);
    x_next = W'((xx - yy) >>> FRAC) + cx;
    // 2*x*y truncated: same bit window taken one position lower in x*y
    y_next = W'(xy >>> (FRAC - 1)) + cy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_iter   <= '0;
      out_inside <= 1'b0;
      pix_w      <= '0;
      pix_h      <= '0;
      px         <= '0;
      py         <= '0;
      cxs        <= '0;
      cys        <= '0;
      dcx        <= '0;
      dcy        <= '0;
      cx         <= '0;
      cy         <= '0;
      x          <= '0;
      y          <= '0;
      max_iter   <= '0;
      i          <= '0;
      xx         <= '0;
      yy         <= '0;
      xy         <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // a start coinciding with the done pulse belongs to the finished frame
            if (cfg_start && !done) begin
              pix_w    <= cfg_pix_w;
              pix_h    <= cfg_pix_h;
              cxs      <= cfg_cxs;
              cys      <= cfg_cys;
              dcx      <= cfg_dcx;
              dcy      <= cfg_dcy;
              max_iter <= cfg_max_iter;
              px       <= '0;
              py       <= '0;
              cx       <= cfg_cxs;
              cy       <= cfg_cys;
              busy     <= 1'b1;
              state    <= (cfg_pix_w == '0 || cfg_pix_h == '0) ? S_DONE : S_INIT;
            end
          end
          S_INIT: begin
            x     <= '0;
            y     <= '0;
            i     <= '0;
            state <= S_MUL;
          end
          S_MUL: begin
            xx    <= (2*W)'(x) * (2*W)'(x);
            yy    <= (2*W)'(y) * (2*W)'(y);
            xy    <= (2*W)'(x) * (2*W)'(y);
            state <= S_CHK;
          end
          S_CHK: begin
            if (escape || i == max_iter) begin
              out_x      <= px;
              out_y      <= py;
              out_iter   <= i;
              out_inside <= !escape;
              out_valid  <= 1'b1;
              state      <= S_WRITE;
            end else begin
              x     <= x_next;
              y     <= y_next;
              i     <= i + ITER_W'(1);
              state <= S_MUL;
            end
          end
          S_WRITE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (px != pix_w - COORD_W'(1)) begin
                px    <= px + COORD_W'(1);
                cx    <= cx + dcx;
                state <= S_INIT;
              end else begin
                px <= '0;
                cx <= cxs;
                if (py != pix_h - COORD_W'(1)) begin
                  py    <= py + COORD_W'(1);
                  cy    <= cy + dcy;
                  state <= S_INIT;
                end else begin
                  state <= S_DONE;
                end
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mandel_engine.sv
// tb/tb_mandel_engine.sv - self-checking bench for mandel_engine
// Directed and randomized frames scored against an arithmetic escape-time model.
module tb_mandel_engine;

  localparam int FRAC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [8:0]  cfg_pix_w, cfg_pix_h;
  logic [15:0] cfg_cxs, cfg_cys, cfg_dcx, cfg_dcy, cfg_max_iter;
  logic        abort;
  logic        busy, done, out_valid, out_ready;
  logic [8:0]  out_x, out_y;
  logic [15:0] out_iter;
  logic        out_inside;

  int total = 0;
  int bad   = 0;

  mandel_engine #(.W(16), .FRAC(FRAC), .ITER_W(16), .COORD_W(9)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_pix_w(cfg_pix_w), .cfg_pix_h(cfg_pix_h),
    .cfg_cxs(cfg_cxs), .cfg_cys(cfg_cys), .cfg_dcx(cfg_dcx), .cfg_dcy(cfg_dcy),
    .cfg_max_iter(cfg_max_iter), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_iter(out_iter), .out_inside(out_inside)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  // escape-time reference: plain integer arithmetic with 16-bit wrap on adds
  task automatic ref_pix(input int px, input int py, input logic [15:0] cxs, cys, dcx, dcy, mi,
                         output int it, output bit ins);
    longint cx, cy, x, y, nx, ny;
    cx = sx(longint'($signed(cxs)) + longint'(px) * longint'($signed(dcx)));
    cy = sx(longint'($signed(cys)) + longint'(py) * longint'($signed(dcy)));
    x = 0;
    y = 0;
    it = 0;
    ins = 1'b0;
    for (int k = 0; k <= int'(mi); k++) begin
      if (x * x + y * y >= (longint'(4) << (2 * FRAC))) begin
        it = k; ins = 1'b0; return;
      end
      if (k == int'(mi)) begin
        it = k; ins = 1'b1; return;
      end
      nx = sx(((x * x - y * y) >>> FRAC) + cx);
      ny = sx(((2 * x * y) >>> FRAC) + cy);
      x = nx;
      y = ny;
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [15:0] cxs, cys, dcx, dcy, mi,
                           input int stall_pct, input int hold_idx,
                           output int first_valid, output int done_cyc,
                           output int last_iter, output int last_ins);
    int n = 0, dones = 0, stall = 0, eit;
    bit pend = 1'b0, held = 1'b0, rdy, eins;
    logic [34:0] hdat;
    cfg_pix_w = 9'(w); cfg_pix_h = 9'(h);
    cfg_cxs = cxs; cfg_cys = cys; cfg_dcx = dcx; cfg_dcy = dcy; cfg_max_iter = mi;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cfg_pix_w = 9'($urandom); cfg_pix_h = 9'($urandom);
    cfg_cxs = 16'($urandom); cfg_cys = 16'($urandom);
    cfg_dcx = 16'($urandom); cfg_dcy = 16'($urandom); cfg_max_iter = 16'($urandom);
    first_valid = -1; done_cyc = -1; last_iter = -1; last_ins = -1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_x, out_y, out_iter, out_inside}, hdat);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        dones++;
        break;
      end
      if (out_valid) begin
        if (n == hold_idx && !held) begin held = 1'b1; stall = 10; end
        rdy = (stall == 0) && ($urandom_range(99) >= stall_pct);
        if (stall > 0) stall--;
        out_ready = rdy;
        if (rdy) begin
          ref_pix(n % w, n / w, cxs, cys, dcx, dcy, mi, eit, eins);
          check("pix_x", out_x, n % w);
          check("pix_y", out_y, n / w);
          check("pix_iter", out_iter, eit);
          check("pix_inside", out_inside, eins);
          last_iter = int'(out_iter);
          last_ins = int'(out_inside);
          n++;
        end
        pend = !rdy;
        hdat = {out_x, out_y, out_iter, out_inside};
      end else begin
        out_ready = 1'($urandom_range(1));
        pend = 1'b0;
      end
      tick;
    end
    check("done_seen", dones, 1);
    check("pix_count", n, w * h);
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    out_ready = 1'b0;
    check("done_single", done, 0);
    check("start_at_done_ignored", busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick;
    end
    check(tag, ok, 1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      if (out_valid || done || busy) seen = 1'b1;
      tick;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int fv, dc, li, lins, w, h;
    rst = 1'b1; cfg_start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_pix_w = '0; cfg_pix_h = '0; cfg_cxs = '0; cfg_cys = '0;
    cfg_dcx = '0; cfg_dcy = '0; cfg_max_iter = '0;
    tick; tick;
    check("rst_state", {busy, done, out_valid, out_x, out_y, out_iter, out_inside}, 0);
    rst = 1'b0;
    tick;

    run_frame(1, 1, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'd100, 0, -1, fv, dc, li, lins);
    check("c1_iter", li, 2);
    check("c1_inside", lins, 0);

    run_frame(1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd100, 0, -1, fv, dc, li, lins);
    check("c0_latency", fv, 203);
    check("c0_iter", li, 100);
    check("c0_inside", lins, 1);

    run_frame(3, 2, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'd50, 0, -1, fv, dc, li, lins);
    check("c2_iter", li, 1);
    run_frame(3, 2, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'd50, 0, 2, fv, dc, li, lins);

    run_frame(0, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd10, 0, -1, fv, dc, li, lins);
    check("empty_done_cycle", dc, 1);
    check("empty_no_valid", fv, -1);

    run_frame(2, 1, 16'h1000, 16'h0800, 16'h0400, 16'h0000, 16'd0, 0, -1, fv, dc, li, lins);
    check("mi0_iter", li, 0);
    check("mi0_inside", lins, 1);

    // abort while pixel 1 is iterating
    cfg_pix_w = 9'd3; cfg_pix_h = 9'd2; cfg_cxs = '0; cfg_cys = '0;
    cfg_dcx = '0; cfg_dcy = '0; cfg_max_iter = 16'd20;
    out_ready = 1'b1; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    wait_valid("abort_pix0_valid");
    tick;
    repeat (5) tick;
    check("abort_mid_busy", busy, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    quiet("abort_quiet", 100);

    // abort wins over a transfer in the same cycle
    cfg_pix_w = 9'd1; cfg_pix_h = 9'd1; cfg_cxs = 16'h2000; cfg_max_iter = 16'd5;
    out_ready = 1'b0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    wait_valid("abort2_valid");
    out_ready = 1'b1; abort = 1'b1;
    tick;
    abort = 1'b0; out_ready = 1'b0;
    check("abort2_valid_drop", out_valid, 0);
    quiet("abort2_quiet", 20);

    run_frame(2, 2, 16'hF000, 16'hFC00, 16'h0800, 16'h0600, 16'd15, 20, -1, fv, dc, li, lins);

    for (int r = 0; r < 4; r++) begin
      w = int'($urandom_range(4, 1));
      h = int'($urandom_range(3, 1));
      run_frame(w, h,
                16'(int'($urandom_range(14336)) - 10240),
                16'(int'($urandom_range(10240)) - 5120),
                16'(int'($urandom_range(1024)) - 512),
                16'(int'($urandom_range(1024)) - 512),
                16'($urandom_range(40)), 30, -1, fv, dc, li, lins);
    end

    // reset in the middle of a frame, while pixel (1,0) waits
    cfg_pix_w = 9'd3; cfg_pix_h = 9'd1; cfg_cxs = 16'h2000; cfg_cys = '0;
    cfg_dcx = '0; cfg_dcy = '0; cfg_max_iter = 16'd9;
    out_ready = 1'b1; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    wait_valid("rst_pix0_valid");
    tick;
    out_ready = 1'b0;
    wait_valid("rst_pix1_valid");
    check("rst_pre_x", out_x, 1);
    rst = 1'b1;
    tick;
    check("rst_mid_frame", {busy, done, out_valid, out_x, out_y, out_iter, out_inside}, 0);
    rst = 1'b0;
    quiet("rst_quiet", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
